// File: rtl/ahb_ext_ram_sub_pkg.sv
// ahb_ext_ram_sub_pkg: shared constants and types for the external-RAM
// AHB-Lite subordinate.
//   - HTRANS encodings
//   - statetype: data-phase FSM states
//   - 8-bit LFSR seed/tap mask used when EXT_RAM_LFSR_WAIT_EN is defined
package ahb_ext_ram_sub_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} statetype;

    // Fibonacci taps 8,6,5,4 map to shift-register bits 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'h5A;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // Wait counter width: covers WAIT_STATES (max 15) plus LFSR add (max 3).
    localparam int WCNT_W = 5;

endpackage

// File: rtl/ahb_ext_ram_sub_waitgen.sv
// ahb_ext_ram_waitgen: per-transfer wait-state counter.
// Optional feature macro: EXT_RAM_LFSR_WAIT_EN (adds 0..3 pseudo-random
// wait states per transfer from an 8-bit LFSR).
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   load         a good transfer is accepted this cycle
//   no_wait      the transfer being loaded needs zero wait states
//   done         counter has reached zero (last wait cycle)
module ahb_ext_ram_waitgen
    import ahb_ext_ram_sub_pkg::*;
#(
    parameter int WAIT_STATES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic no_wait,
    output logic done
);

    logic [WCNT_W-1:0] total;
    logic [WCNT_W-1:0] cnt;

`ifdef EXT_RAM_LFSR_WAIT_EN
    logic [7:0] lfsr;

    // The current value sets this transfer's count; it then steps once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     lfsr <= LFSR_SEED;
        else if (load) lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
    end

    assign total = WCNT_W'(WAIT_STATES) + {3'b000, lfsr[1:0]};
`else
    assign total = WCNT_W'(WAIT_STATES);
`endif

    assign no_wait = (total == '0);

    // Loaded with total-1 so that WAIT lasts exactly 'total' cycles;
    // free-runs down to zero and parks there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)             cnt <= '0;
        else if (load)         cnt <= no_wait ? '0 : total - WCNT_W'(1);
        else if (cnt != '0)    cnt <= cnt - WCNT_W'(1);
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/ahb_ext_ram_sub.sv
// ahb_ext_ram_sub: AHB-Lite external RAM subordinate with programmable
// wait states and two-cycle ERROR responses.
// Optional feature macro: EXT_RAM_LFSR_WAIT_EN (random extra wait states,
// handled inside ahb_ext_ram_waitgen).
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   HSEL              subordinate select
//   HADDR/HWRITE/HSIZE/HTRANS   address phase
//   HWDATA/HWSTRB     write data phase
//   HREADY            global bus ready
//   HRDATA            read data (zero outside a read data cycle)
//   HREADYOUT, HRESP  subordinate ready / error response
module ahb_ext_ram_sub
    import ahb_ext_ram_sub_pkg::*;
#(
    parameter int AHBW        = 64,
    parameter int PA_BITS     = 56,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 HSEL,
    input  logic [PA_BITS-1:0]   HADDR,
    input  logic [AHBW-1:0]      HWDATA,
    input  logic [AHBW/8-1:0]    HWSTRB,
    input  logic                 HWRITE,
    input  logic [2:0]           HSIZE,
    input  logic [1:0]           HTRANS,
    input  logic                 HREADY,
    output logic [AHBW-1:0]      HRDATA,
    output logic                 HREADYOUT,
    output logic                 HRESP
);

    localparam int BYTE_BITS = $clog2(AHBW/8);
    localparam int IDX_BITS  = $clog2(DEPTH);
    localparam int MEM_BITS  = IDX_BITS + BYTE_BITS;

    statetype state, next_state;

    logic                accept, take, bad, load;
    logic                no_wait, done;
    logic [7:0]          amask;
    logic [IDX_BITS-1:0] idx_q;
    logic                wr_q;
    logic [AHBW-1:0]     mem [DEPTH];

    // IDLE/BUSY while selected fall through as zero-wait OKAY.
    assign accept = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
    // Only IDLE and DATA can take a new address phase; ERR2 drops it.
    assign take   = accept & ((state == IDLE) | (state == DATA));

    assign amask  = (8'd1 << HSIZE) - 8'd1;
    assign bad    = (|HADDR[PA_BITS-1:MEM_BITS])
                  | (HSIZE > 3'(BYTE_BITS))
                  | (|(HADDR[7:0] & amask));
    assign load   = take & ~bad;

    ahb_ext_ram_waitgen #(
        .WAIT_STATES (WAIT_STATES)
    ) u_waitgen (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .no_wait (no_wait),
        .done    (done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Size is not kept: the strobes already say which bytes to write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
            wr_q  <= 1'b0;
        end else if (load) begin
            idx_q <= HADDR[MEM_BITS-1:BYTE_BITS];
            wr_q  <= HWRITE;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DATA: begin
                if (take) begin
                    if (bad)          next_state = ERR1;
                    else if (no_wait) next_state = DATA;
                    else              next_state = WAIT;
                end else begin
                    next_state = IDLE;
                end
            end
            WAIT:    if (done) next_state = DATA;
            ERR1:    next_state = ERR2;
            ERR2:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign HREADYOUT = ~((state == WAIT) | (state == ERR1));
    assign HRESP     = (state == ERR1) | (state == ERR2);
    assign HRDATA    = ((state == DATA) & ~wr_q) ? mem[idx_q] : '0;

    // Commit at the edge ending DATA, so a pipelined read of the same
    // word (whose DATA comes later) already sees the new bytes.
    always_ff @(posedge clk) begin
        if (!reset && (state == DATA) && wr_q) begin
            for (int i = 0; i < AHBW/8; i++) begin
                if (HWSTRB[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_ext_ram_sub.sv
module tb_ahb_ext_ram_sub;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        HSEL;
    logic [55:0] HADDR;
    logic [63:0] HWDATA;
    logic [7:0]  HWSTRB;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [63:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ahb_ext_ram_sub #(
        .AHBW(64), .PA_BITS(56), .DEPTH(1024), .WAIT_STATES(W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HWSTRB    (HWSTRB),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HTRANS    (HTRANS),
        .HREADY    (HREADYOUT),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Transfer-level model: a data phase lasts W+1 cycles (last one ready),
    // an error lasts two cycles; memory is a plain word array.
    logic [63:0] ref_mem [1024];
    int          m_busy = 0;
    int          m_err  = 0;
    logic        m_wr   = 1'b0;
    int          m_idx  = 0;

    always @(posedge clk or posedge reset) begin
        bit acc, e;
        if (reset) begin
            m_busy = 0;
            m_err  = 0;
        end else begin
            if (m_busy == 1 && m_wr)
                for (int i = 0; i < 8; i++)
                    if (HWSTRB[i]) ref_mem[m_idx][8*i +: 8] = HWDATA[8*i +: 8];
            acc = (m_err == 0) && (m_busy <= 1) && HSEL && HTRANS[1];
            e   = (HADDR >= 56'd8192) || (HSIZE > 3'd3) ||
                  ((HADDR % (56'd1 << HSIZE)) != 56'd0);
            if (m_busy > 0) m_busy--;
            if (m_err > 0)  m_err--;
            if (acc) begin
                if (e) m_err = 2;
                else begin
                    m_busy = W + 1;
                    m_wr   = HWRITE;
                    m_idx  = int'((HADDR / 56'd8) % 56'd1024);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic        e_rdy, e_rsp;
        logic [63:0] e_dat;
        e_rdy = 1'b1; e_rsp = 1'b0; e_dat = '0;
        if (m_err == 2)      begin e_rdy = 1'b0; e_rsp = 1'b1; end
        else if (m_err == 1) e_rsp = 1'b1;
        else if (m_busy > 1) e_rdy = 1'b0;
        else if (m_busy == 1 && !m_wr) e_dat = ref_mem[m_idx];
        chk("model_hreadyout", {63'd0, HREADYOUT}, {63'd0, e_rdy});
        chk("model_hresp",     {63'd0, HRESP},     {63'd0, e_rsp});
        chk("model_hrdata",    HRDATA,             e_dat);
    end

    task automatic xfer(input logic [55:0] a, input logic w, input logic [2:0] sz,
                        input logic [63:0] wd, input logic [7:0] st,
                        output logic [63:0] rd, output int waits, output logic rsp);
        @(negedge clk);
        HSEL = 1'b1; HADDR = a; HWRITE = w; HSIZE = sz; HTRANS = 2'b10;
        @(negedge clk);
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wd; HWSTRB = st;
        waits = 0;
        while (!HREADYOUT && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= 40) chk("xfer_timeout", 64'd1, 64'd0);
        rd  = HRDATA;
        rsp = HRESP;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        int          wt, cyc;
        logic        rsp;

        reset = 1'b1; HSEL = 1'b0; HADDR = '0; HWDATA = '0; HWSTRB = '0;
        HWRITE = 1'b0; HSIZE = 3'd0; HTRANS = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset_hreadyout", {63'd0, HREADYOUT}, 64'd1);
        chk("reset_hresp",     {63'd0, HRESP},     64'd0);
        chk("reset_hrdata",    HRDATA,             64'd0);
        reset = 1'b0;

        // 1: full-word write then read
        xfer(56'h10, 1'b1, 3'd3, 64'h1122334455667788, 8'hFF, rd, wt, rsp);
        chk("t1_wr_waits", 64'(wt), 64'd2);
        chk("t1_wr_resp", {63'd0, rsp}, 64'd0);
        xfer(56'h10, 1'b0, 3'd3, 64'd0, 8'h00, rd, wt, rsp);
        chk("t1_rd_waits", 64'(wt), 64'd2);
        chk("t1_rd_data", rd, 64'h1122334455667788);

        // 2: byte write to byte 3
        xfer(56'h13, 1'b1, 3'd0, 64'h00000000AB000000, 8'h08, rd, wt, rsp);
        xfer(56'h10, 1'b0, 3'd3, 64'd0, 8'h00, rd, wt, rsp);
        chk("t2_rd_data", rd, 64'h11223344AB667788);

        // 3: out-of-range read
        xfer(56'h2000, 1'b0, 3'd3, 64'd0, 8'h00, rd, wt, rsp);
        chk("t3_err1_cycles", 64'(wt), 64'd1);
        chk("t3_err2_resp", {63'd0, rsp}, 64'd1);

        // 4: misaligned word write must not commit
        xfer(56'h12, 1'b1, 3'd2, 64'hFFFFFFFFFFFFFFFF, 8'hFF, rd, wt, rsp);
        chk("t4_err1_cycles", 64'(wt), 64'd1);
        chk("t4_err2_resp", {63'd0, rsp}, 64'd1);
        xfer(56'h10, 1'b0, 3'd3, 64'd0, 8'h00, rd, wt, rsp);
        chk("t4_rd_data", rd, 64'h11223344AB667788);

        // 5: pipelined write then read of the same word
        @(negedge clk);
        HSEL = 1'b1; HADDR = 56'h20; HWRITE = 1'b1; HSIZE = 3'd3; HTRANS = 2'b10;
        @(negedge clk);
        HWDATA = 64'hDEADBEEF00000001; HWSTRB = 8'hFF;
        HWRITE = 1'b0;
        cyc = 1;
        while (!HREADYOUT && cyc < 40) begin @(negedge clk); cyc++; end
        chk("t5_wr_done_cycle", 64'(cyc), 64'd3);
        @(negedge clk);
        HSEL = 1'b0; HTRANS = 2'b00; HWSTRB = 8'h00;
        cyc++;
        while (!HREADYOUT && cyc < 40) begin @(negedge clk); cyc++; end
        chk("t5_rd_done_cycle", 64'(cyc), 64'd6);
        chk("t5_rd_data", HRDATA, 64'hDEADBEEF00000001);

        // 6: reset in the middle of a write's wait states
        xfer(56'h30, 1'b1, 3'd3, 64'h0123456789ABCDEF, 8'hFF, rd, wt, rsp);
        @(negedge clk);
        HSEL = 1'b1; HADDR = 56'h30; HWRITE = 1'b1; HSIZE = 3'd3; HTRANS = 2'b10;
        @(negedge clk);
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 64'hFFFFFFFFFFFFFFFF; HWSTRB = 8'hFF;
        chk("t6_in_wait", {63'd0, HREADYOUT}, 64'd0);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_hreadyout", {63'd0, HREADYOUT}, 64'd1);
        chk("t6_rst_hresp",     {63'd0, HRESP},     64'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        xfer(56'h30, 1'b0, 3'd3, 64'd0, 8'h00, rd, wt, rsp);
        chk("t6_rd_data", rd, 64'h0123456789ABCDEF);
        chk("t6_rd_waits", 64'(wt), 64'd2);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
